// File: rtl/rrarbiter_if.sv
// Request/grant bundle shared between requesters and the round-robin arbiter.
// The Lock signal exists only when RRARB_LOCK_EN is defined.
interface rrarbiter_if #(
   parameter int N = 4
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  Req;
   logic          Done;
   logic [N-1:0]  Grant;
   logic [IW-1:0] GrantIdx;
   logic          Busy;
`ifdef RRARB_LOCK_EN
   logic          Lock;

   modport master (output Req, Done, Lock, input Grant, GrantIdx, Busy);
   modport slave  (input Req, Done, Lock, output Grant, GrantIdx, Busy);
`else
   modport master (output Req, Done, input Grant, GrantIdx, Busy);
   modport slave  (input Req, Done, output Grant, GrantIdx, Busy);
`endif
endinterface

// File: rtl/rrarbiter.sv
// Round-robin arbiter: N requesters share one resource. The grant is registered
// and held for a whole transaction until Done; the finishing holder drops to
// lowest priority and the next winner is granted in the same cycle.
// Optional macro RRARB_LOCK_EN adds Lock: Done with Lock=1 keeps the grant.
module rrarbiter #(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        reset,
   rrarbiter_if.slave  bus
);
   localparam int IW = $clog2(N);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_reg, state_next;
   logic [N-1:0]  grant_reg, grant_next;
   logic [N-1:0]  primask_reg, primask_next;
   logic [IW-1:0] grant_idx;
   logic [N-1:0]  mask_after;
   logic [N-1:0]  sel_mask;
   logic [N-1:0]  masked;
   logic [N-1:0]  winner;
   logic          lock_eff;

`ifdef RRARB_LOCK_EN
   assign lock_eff = bus.Lock;
`else
   assign lock_eff = 1'b0;
`endif

   // Binary index of the one-hot grant; zero while idle.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_reg[i]) grant_idx = grant_idx | IW'(i);
      end
   end

   // Priority mask that takes effect once the current holder finishes:
   // only requesters strictly above the holder keep priority.
   for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask_after[gi] = (IW'(gi) > grant_idx);
   end

   // While busy, selection already uses the post-Done mask so the handover
   // needs no idle cycle; in IDLE the stored mask applies.
   assign sel_mask = (state_reg == BUSY) ? mask_after : primask_reg;
   assign masked   = bus.Req & sel_mask;

   // Lowest-set-bit one-hot of the masked vector, falling back to raw Req.
   always_comb begin
      if (|masked) winner = masked & (~masked + ONE);
      else         winner = bus.Req & (~bus.Req + ONE);
   end

   // Next-state logic: grant on request in IDLE, hand over or release on Done.
   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      primask_next = primask_reg;
      case (state_reg)
         IDLE: begin
            if (|bus.Req) begin
               grant_next = winner;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (bus.Done && !lock_eff) begin
               primask_next = mask_after;
               if (|bus.Req) begin
                  grant_next = winner;
               end else begin
                  grant_next = '0;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // State, grant and priority registers; reset clears them immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         grant_reg   <= '0;
         primask_reg <= '1;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         primask_reg <= primask_next;
      end
   end

   assign bus.Grant    = grant_reg;
   assign bus.GrantIdx = grant_idx;
   assign bus.Busy     = |grant_reg;
endmodule

// File: tb/tb_rrarbiter.sv
// Directed bench for rrarbiter (N=4). Inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_rrarbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rrarbiter_if #(.N(4)) arb_if ();

   rrarbiter #(.N(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (arb_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic busy);
      chk({tag, ".grant"}, 32'(arb_if.Grant), 32'(g));
      chk({tag, ".idx"},   32'(arb_if.GrantIdx), 32'(idx));
      chk({tag, ".busy"},  32'(arb_if.Busy), 32'(busy));
      $display("step %-12s Req=%b Grant=%b Idx=%0d Busy=%b", tag, arb_if.Req, arb_if.Grant, arb_if.GrantIdx, arb_if.Busy);
   endtask

   initial begin
      arb_if.Req  = 4'b0000;
      arb_if.Done = 1'b0;
`ifdef RRARB_LOCK_EN
      arb_if.Lock = 1'b0;
`endif
      @(negedge clk);
      chk_grant("reset", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;

      // First grant: bit 0 has highest priority after reset.
      arb_if.Req = 4'b0101;
      @(negedge clk);
      chk_grant("first", 4'b0001, 2'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_grant("hold", 4'b0001, 2'd0, 1'b1);
      end

      // Rotation on Done pulses, no idle bubble.
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("rot2", 4'b0100, 2'd2, 1'b1);
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("rot0", 4'b0001, 2'd0, 1'b1);

      // Grant index 3, then wrap to unmasked request.
      arb_if.Req  = 4'b1000;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("idx3", 4'b1000, 2'd3, 1'b1);
      arb_if.Req  = 4'b1001;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("wrap", 4'b0001, 2'd0, 1'b1);

      // Release to IDLE; Done in IDLE does nothing.
      arb_if.Req  = 4'b0000;
      arb_if.Done = 1'b1;
      @(negedge clk);
      chk_grant("release", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("idle_done", 4'b0000, 2'd0, 1'b0);
      arb_if.Req = 4'b0010;
      @(negedge clk);
      chk_grant("idle_req", 4'b0010, 2'd1, 1'b1);

      // Holder drops Req, others change: grant held without Done.
      arb_if.Req = 4'b0000;
      @(negedge clk);
      chk_grant("drop_req", 4'b0010, 2'd1, 1'b1);
      arb_if.Req = 4'b1101;
      @(negedge clk);
      chk_grant("other_req", 4'b0010, 2'd1, 1'b1);

      // Sole requester re-granted; then holder yields to higher index.
      arb_if.Req  = 4'b0010;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("regrant", 4'b0010, 2'd1, 1'b1);
      arb_if.Req  = 4'b0111;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("yield", 4'b0100, 2'd2, 1'b1);

      // Holder re-requesting ranks lowest: from index 2, wrap goes to 0.
      arb_if.Req  = 4'b0101;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("holder_low", 4'b0001, 2'd0, 1'b1);
      arb_if.Req  = 4'b0100;
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("back_to2", 4'b0100, 2'd2, 1'b1);

      // Asynchronous reset mid-cycle clears grant before the next edge.
      #2 reset = 1'b1;
      #1 chk_grant("async_rst", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      arb_if.Req = 4'b1111;
      reset = 1'b0;
      @(negedge clk);
      chk_grant("after_rst", 4'b0001, 2'd0, 1'b1);

      // Done with Req=0011 while holding 0001.
      arb_if.Req = 4'b0011;
`ifdef RRARB_LOCK_EN
      arb_if.Lock = 1'b1;
      arb_if.Done = 1'b1;
      @(negedge clk);
      chk_grant("locked1", 4'b0001, 2'd0, 1'b1);
      @(negedge clk);
      chk_grant("locked2", 4'b0001, 2'd0, 1'b1);
      arb_if.Lock = 1'b0;
`endif
      arb_if.Done = 1'b1;
      @(negedge clk);
      arb_if.Done = 1'b0;
      chk_grant("unlocked", 4'b0010, 2'd1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rrarbiter.md
Name: rrarbiter

Overview:
- Round-robin arbiter that shares one resource (bus port, cache fill path, shared FPU) among N requesters.
- Rotating-priority selection built from the least-significant-one priority one-hot primitive, applied to a masked and an unmasked request vector.
- Grants are registered and held for a whole transaction until the holder signals Done.
- Winner hands back-to-back to the next requester with no idle bubble.

Parameters:
- N, 4, number of requesters (N >= 2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- Req  input  N  per-requester request, level-sensitive
- Done  input  1  current grant holder finishes its transaction this cycle
- Grant  output  N  registered one-hot grant; all zeros when idle
- GrantIdx  output  $clog2(N)  binary index of the asserted Grant bit; 0 when idle
- Busy  output  1  high while a grant is held (equals |Grant)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: Grant=0, GrantIdx=0, Busy=0, state IDLE, priority mask PriMask={N{1}}. After reset, bit 0 has highest priority.
- Selection (combinational):
  - Masked = Req & PriMask.
  - Winner = priorityonehot(Masked) if |Masked, else priorityonehot(Req).
  - Winner is always one-hot or zero.
- State IDLE:
  - If |Req: load Grant<=Winner, go to BUSY. Grant visible in the cycle after Req is sampled (latency 1).
  - If Req=0: stay IDLE.
  - Done in IDLE is ignored.
- State BUSY:
  - Grant is held constant. Holder dropping its Req without Done does not release the grant. Req changes from other requesters have no effect.
  - Done=1: PriMask<=bits strictly above the current GrantIdx (PriMask[i]=1 iff i>GrantIdx).
  - Done=1 with Req != 0: re-arbitrate in the same cycle, using the updated mask computed from the finishing grant. Grant<=new Winner, stay BUSY.
  - Done=1 with Req == 0: Grant<=0, go to IDLE.
- Wrap-around: after granting index N-1, PriMask=0, so selection falls back to unmasked Req and index 0 wins.
- Holder re-request: a holder that keeps Req high through Done ranks lowest at re-arbitration. It is regranted only if no other requester is active.
- Fairness: any continuously asserted requester is granted within N-1 completed transactions.
- GrantIdx is an encoding of Grant with no separate state. Busy = |Grant.
- Reset mid-transaction: Grant, GrantIdx and Busy clear immediately (asynchronous) and PriMask returns to all ones. The in-flight transaction is abandoned; owning the consequences is the requester's job.
- Simultaneous events: Done and a new Req arriving in the same cycle are both considered in the same re-arbitration.

Optional Feature:
- Macro: RRARB_LOCK_EN.
- Defined:
  - Adds input port Lock (1 bit).
  - Done while Lock=1 keeps the current Grant, does not advance PriMask, and stays BUSY. This supports atomic multi-transaction sequences (e.g. AMO/LR-SC on a shared bus).
  - Lock is ignored in IDLE.
  - Reset clears lock effects.
- Undefined: no Lock port; behaviour identical to Lock tied 0.

Test Plan:
- Reset, then Req=4'b0101 -> next cycle Grant=4'b0001, GrantIdx=0, Busy=1. Grant holds while Done=0 for 5 cycles.
- Holding Req=4'b0101, pulse Done -> next cycle Grant=4'b0100, GrantIdx=2. Pulse Done again -> Grant=4'b0001 (rotation, no idle bubble).
- Req=4'b1000 granted (GrantIdx=3), then Done with Req=4'b1001 -> Grant=4'b0001 (wrap to unmasked).
- Done with Req=4'b0000 -> next cycle Grant=0, Busy=0. Done pulses in IDLE -> no grant. Req=4'b0010 -> Grant=4'b0010 one cycle later.
- During Grant=4'b0100, assert reset mid-cycle -> Grant=0 before the next clk edge. Release reset with Req=4'b1111 -> Grant=4'b0001.
- RRARB_LOCK_EN: Grant=4'b0001, Req=4'b0011, Lock=1, Done=1 -> Grant stays 4'b0001. Lock=0, Done=1 -> Grant=4'b0010.
